// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline constants, opcodes and inter-stage bundles.
// Imported by every pipeline stage.
package riscv_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Holds fetched {pc, instr} entries and pending request PCs.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~flush & ~empty;
  // Full plus a same-cycle pop still has room.
  assign do_push = push & ~flush & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, credit-based imem fetch,
// fetch buffer to decode, and redirect flush with stale-response drop.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = XLEN + ILEN;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW-1:0]   aq_count;
  logic [CW:0]     used;
  logic [XLEN-1:0] aq_head;
  logic [BW-1:0]   buf_head;
  logic            accept;
  logic            rsp_ok;
  logic            fresh;
  logic            buf_empty;
  logic            buf_pop;

  assign used      = {1'b0, count} + {1'b0, inflight};
  assign buf_empty = (count == '0);

  assign imem_req_valid = rst_n & ~redirect_valid
                        & (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp_ok = imem_rsp_valid & (inflight != '0);
  assign fresh  = rsp_ok & (drop == '0) & ~redirect_valid;

  assign id_valid = ~buf_empty & ~redirect_valid;
  assign buf_pop  = id_valid & id_ready;
  assign id_pc    = buf_empty ? '0 : buf_head[BW-1:ILEN];
  assign id_instr = buf_empty ? '0 : buf_head[ILEN-1:0];

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (pc),
    .pop       (fresh),
    .flush     (redirect_valid),
    .head      (aq_head),
    .count     (aq_count)
  );

  fetch_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fresh),
    .push_data ({aq_head, imem_rsp_data}),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .head      (buf_head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Every still-outstanding request belongs to the old path.
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= inflight - CW'(rsp_ok);
      drop     <= inflight - CW'(rsp_ok);
    end else begin
      if (accept) pc <= pc + XLEN'(INSTR_BYTES);
      inflight <= inflight + CW'(accept) - CW'(rsp_ok);
      if (rsp_ok && drop != '0) drop <= drop - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid && inflight == '0));
      assert (!(fresh && count == CW'(DEPTH) && !buf_pop));
      assert (!(fresh && aq_count == '0));
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a 1-cycle imem model.
// Expected {pc,instr} are queued on request accept and popped on decode.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  int n_deliv = 0;
  logic rsp_en = 1'b1;
  logic [63:0] exp_pc = RST_PC;
  logic [95:0] exp_item;
  logic [63:0] mem_q[$];
  logic [95:0] sb[$];
  logic [63:0] acc_log[$];

  if_fetch_unit #(.XLEN(64), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  // imem model: answers accepted requests in order, one cycle later
  initial forever begin
    @(posedge clk);
    #1;
    imem_rsp_valid = rsp_en && (mem_q.size() > 0);
    imem_rsp_data  = imem_rsp_valid ? word(mem_q[0]) : 32'h0;
  end

  // monitor: request address model and decode-side scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mem_q.delete();
      sb.delete();
      exp_pc = RST_PC;
    end else begin
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (redirect_valid) begin
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL redirect_quiet: id_valid=%b req_valid=%b, required 0 0",
                   id_valid, imem_req_valid);
        end
        sb.delete();
        exp_pc = redirect_pc & ~64'h3;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          checks++;
          if (imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_pc);
          end
          mem_q.push_back(imem_req_addr);
          sb.push_back({exp_pc, word(exp_pc)});
          acc_log.push_back(imem_req_addr);
          n_acc++;
          exp_pc = exp_pc + 64'd4;
        end
        if (id_valid && id_ready) begin
          checks++;
          n_deliv++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL id_extra: got pc %h instr %h, required nothing", id_pc, id_instr);
          end else begin
            exp_item = sb.pop_front();
            if ({id_pc, id_instr} !== exp_item) begin
              errors++;
              $display("FAIL id_data: got %h/%h, required %h/%h",
                       id_pc, id_instr, exp_item[95:32], exp_item[31:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    rsp_en = 1'b1;
    imem_req_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_id(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: req=%b id=%b, required 0 0", imem_req_valid, id_valid);
    end
    checks++;
    if (id_pc !== 64'h0 || id_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_id_data: got %h/%h, required 0/0", id_pc, id_instr);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errors++;
      $display("FAIL reset_first_req: valid=%b addr=%h, required 1 %h",
               imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    bit ok;
    int d0;
    do_reset();
    id_ready = 1'b1;
    wait_id(ok);
    checks++;
    if (!ok || id_pc !== 64'h0 || id_instr !== word(64'h0)) begin
      errors++;
      $display("FAIL stream_first: valid=%b pc=%h, required 1 0", ok, id_pc);
    end
    d0 = n_deliv;
    repeat (30) tick();
    checks++;
    if (n_deliv - d0 < 15) begin
      errors++;
      $display("FAIL stream_rate: got %0d in 30 cycles, required >=15", n_deliv - d0);
    end
  endtask

  task automatic test_stall();
    int a0;
    int d0;
    int moved;
    do_reset();
    a0 = n_acc;
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (id_valid && id_pc !== 64'h0) moved++;
    end
    checks++;
    if (n_acc - a0 != DEPTH) begin
      errors++;
      $display("FAIL stall_issue: got %0d requests, required %0d", n_acc - a0, DEPTH);
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 64'h0 || moved != 0) begin
      errors++;
      $display("FAIL stall_hold: valid=%b pc=%h moved=%0d, required 1 0 0",
               id_valid, id_pc, moved);
    end
    tick();
    id_ready = 1'b1;
    d0 = n_deliv;
    repeat (12) tick();
    checks++;
    if (n_deliv - d0 < 4) begin
      errors++;
      $display("FAIL stall_release: got %0d delivered, required >=4", n_deliv - d0);
    end
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    int a0;
    int s;
    do_reset();
    id_ready = 1'b1;
    rsp_en = 1'b0;
    a0 = n_acc;
    repeat (5) tick();
    checks++;
    if (n_acc - a0 != 2) begin
      errors++;
      $display("FAIL inflight_count: got %0d, required 2", n_acc - a0);
    end
    s = acc_log.size();
    redirect_valid = 1'b1;
    redirect_pc = 64'h1002;
    tick();
    redirect_valid = 1'b0;
    rsp_en = 1'b1;
    wait_id(ok);
    checks++;
    if (!ok || id_pc !== 64'h1000 || id_instr !== word(64'h1000)) begin
      errors++;
      $display("FAIL redirect_first: valid=%b pc=%h, required 1 1000", ok, id_pc);
    end
    checks++;
    if (acc_log.size() <= s || acc_log[s] !== 64'h1000) begin
      errors++;
      $display("FAIL redirect_addr: got %0d new requests, required first at 1000",
               acc_log.size() - s);
    end
  endtask

  task automatic test_redirect_rsp();
    bit ok;
    bit found;
    do_reset();
    id_ready = 1'b1;
    found = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      if (imem_rsp_valid && id_valid) begin
        found = 1'b1;
        break;
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h400;
    @(negedge clk);
    checks++;
    if (!found || imem_rsp_valid !== 1'b1 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_rsp_cycle: found=%b rsp=%b id_valid=%b, required 1 1 0",
               found, imem_rsp_valid, id_valid);
    end
    tick();
    redirect_valid = 1'b0;
    wait_id(ok);
    checks++;
    if (!ok || id_pc !== 64'h400 || id_instr !== word(64'h400)) begin
      errors++;
      $display("FAIL redirect_rsp_first: valid=%b pc=%h, required 1 400", ok, id_pc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    id_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    tick();
    redirect_pc = 64'h300;
    tick();
    redirect_valid = 1'b0;
    wait_id(ok);
    checks++;
    if (!ok || id_pc !== 64'h300 || id_instr !== word(64'h300)) begin
      errors++;
      $display("FAIL b2b_redirect: valid=%b pc=%h, required 1 300", ok, id_pc);
    end
  endtask

  task automatic test_wrap();
    int s;
    do_reset();
    id_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    s = acc_log.size();
    for (int i = 0; i < 30; i++) begin
      if (acc_log.size() >= s + 2) break;
      tick();
    end
    checks++;
    if (acc_log.size() < s + 2) begin
      errors++;
      $display("FAIL wrap_issue: got %0d requests, required 2", acc_log.size() - s);
    end else if (acc_log[s] !== 64'hFFFF_FFFF_FFFF_FFFC || acc_log[s+1] !== 64'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h %h, required fffffffffffffffc 0",
               acc_log[s], acc_log[s+1]);
    end
    repeat (10) tick();
  endtask

  task automatic test_random();
    int d0;
    do_reset();
    d0 = n_deliv;
    for (int i = 0; i < 400; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      imem_req_ready = ($urandom_range(0, 3) != 0);
      rsp_en = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = {$urandom, $urandom};
      tick();
    end
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    rsp_en = 1'b1;
    repeat (20) tick();
    checks++;
    if (n_deliv - d0 < 50) begin
      errors++;
      $display("FAIL random_progress: got %0d delivered, required >=50", n_deliv - d0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_rsp();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
